wb_regfile: RTL and testbench

//   Writeback stage plus integer register file of the 5-stage RISC-V pipeline; consumes MEM/WB register outputs.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/wb_regfile_if.sv | 54 +++++
 rtl/wb_regfile_rf_bank.sv | 32 +++
 rtl/wb_regfile.sv | 63 ++++++
 tb/tb_wb_regfile.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and writeback bus types.
// Pure declarations: no latency or flow control.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;

   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   typedef logic [XLEN-1:0]   xword_t;
   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef struct packed {
      logic      en;
      reg_addr_t rd;
      xword_t    data;
   } wb_bus_t;

   function automatic logic is_x0(input reg_addr_t a);
      return a == REG_X0;
   endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback inputs, ID read ports and forwarding outputs of the register file.
// Master drives MEM/WB fields and read addresses; no handshake, the pipeline advances every cycle.
interface wb_regfile_if #(
   parameter int CNT_W = riscv_pkg::CNT_W
);
   import riscv_pkg::*;

   reg_addr_t        mem_wb_register_rd;
   xword_t           result_mem_wb;
   xword_t           read_data_mem_wb;
   logic             mem_wb_memtoreg;
   logic             mem_wb_regwrite;
   reg_addr_t        rs1_addr;
   reg_addr_t        rs2_addr;
   xword_t           rs1_data;
   xword_t           rs2_data;
   xword_t           wb_data;
   reg_addr_t        wb_rd;
   logic             wb_en;
   logic [CNT_W-1:0] wb_count;

   modport master (
      output mem_wb_register_rd,
      output result_mem_wb,
      output read_data_mem_wb,
      output mem_wb_memtoreg,
      output mem_wb_regwrite,
      output rs1_addr,
      output rs2_addr,
      input  rs1_data,
      input  rs2_data,
      input  wb_data,
      input  wb_rd,
      input  wb_en,
      input  wb_count
   );

   modport slave (
      input  mem_wb_register_rd,
      input  result_mem_wb,
      input  read_data_mem_wb,
      input  mem_wb_memtoreg,
      input  mem_wb_regwrite,
      input  rs1_addr,
      input  rs2_addr,
      output rs1_data,
      output rs2_data,
      output wb_data,
      output wb_rd,
      output wb_en,
      output wb_count
   );

endinterface

// File: rtl/wb_regfile_rf_bank.sv
// 2R1W integer register storage; x0 reads as zero and is never written.
// Write lands on the next clk edge, reads are combinational; no backpressure.
module rf_bank
   import riscv_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      we,
   input  reg_addr_t waddr,
   input  xword_t    wdata,
   input  reg_addr_t raddr1,
   input  reg_addr_t raddr2,
   output xword_t    rdata1,
   output xword_t    rdata2
);

   xword_t regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !is_x0(waddr)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = is_x0(raddr1) ? '0 : regs[raddr1];
   assign rdata2 = is_x0(raddr2) ? '0 : regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback select, register file with same-cycle write-through to ID, committed-write counter.
// Writes commit one edge after MEM/WB presents them, reads are combinational; no stall path.
module wb_regfile
   import riscv_pkg::*;
#(
   parameter int CNT_W = riscv_pkg::CNT_W
)(
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);

   wb_bus_t          wb;
   xword_t           bank_rs1;
   xword_t           bank_rs2;
   logic [CNT_W-1:0] wb_count_q;

   // Reset masks the write so an in-flight MEM/WB result in the reset cycle is dropped.
   always_comb begin
      wb.data = bus.mem_wb_memtoreg ? bus.read_data_mem_wb : bus.result_mem_wb;
      wb.rd   = bus.mem_wb_register_rd;
      wb.en   = bus.mem_wb_regwrite && !is_x0(bus.mem_wb_register_rd) && !rst;
   end

   rf_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (wb.en),
      .waddr  (wb.rd),
      .wdata  (wb.data),
      .raddr1 (bus.rs1_addr),
      .raddr2 (bus.rs2_addr),
      .rdata1 (bank_rs1),
      .rdata2 (bank_rs2)
   );

   function automatic xword_t read_port(input reg_addr_t a, input xword_t stored, input wb_bus_t w);
      if (is_x0(a)) begin
         return '0;
      end
      if (w.en && (w.rd == a)) begin
         return w.data;
      end
      return stored;
   endfunction

   assign bus.rs1_data = read_port(bus.rs1_addr, bank_rs1, wb);
   assign bus.rs2_data = read_port(bus.rs2_addr, bank_rs2, wb);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count_q <= '0;
      end else if (wb.en) begin
         wb_count_q <= wb_count_q + CNT_W'(1);
      end
   end

   assign bus.wb_data  = wb.data;
   assign bus.wb_rd    = wb.rd;
   assign bus.wb_en    = wb.en;
   assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios then random MEM/WB traffic against an array model.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wb_regfile_if                bus  ();
   wb_regfile_if #(.CNT_W(4))   bus4 ();

   assign bus4.mem_wb_register_rd = bus.mem_wb_register_rd;
   assign bus4.result_mem_wb      = bus.result_mem_wb;
   assign bus4.read_data_mem_wb   = bus.read_data_mem_wb;
   assign bus4.mem_wb_memtoreg    = bus.mem_wb_memtoreg;
   assign bus4.mem_wb_regwrite    = bus.mem_wb_regwrite;
   assign bus4.rs1_addr           = bus.rs1_addr;
   assign bus4.rs2_addr           = bus.rs2_addr;

   wb_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [32];
   logic [31:0] cnt;
   logic [3:0]  cnt4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [4:0] rd, input logic m2r,
                        input logic [31:0] res, input logic [31:0] ld,
                        input logic [4:0] a1, input logic [4:0] a2);
      rst                    = r;
      bus.mem_wb_regwrite    = we;
      bus.mem_wb_register_rd = rd;
      bus.mem_wb_memtoreg    = m2r;
      bus.result_mem_wb      = res;
      bus.read_data_mem_wb   = ld;
      bus.rs1_addr           = a1;
      bus.rs2_addr           = a2;
   endtask

   function automatic logic [31:0] selected();
      return bus.mem_wb_memtoreg ? bus.read_data_mem_wb : bus.result_mem_wb;
   endfunction

   function automatic logic commits();
      return !rst && bus.mem_wb_regwrite && (bus.mem_wb_register_rd != 5'd0);
   endfunction

   // What ID must see: zero for x0, the value being written this cycle, else architectural state.
   function automatic logic [31:0] expect_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (commits() && bus.mem_wb_register_rd == a) return selected();
      return model[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
         cnt  = 32'd0;
         cnt4 = 4'd0;
      end else if (commits()) begin
         model[bus.mem_wb_register_rd] = selected();
         cnt  = cnt + 32'd1;
         cnt4 = cnt4 + 4'd1;
      end
   endtask

   task automatic cycle();
      #1;
      check("rs1_data", bus.rs1_data, expect_read(bus.rs1_addr));
      check("rs2_data", bus.rs2_data, expect_read(bus.rs2_addr));
      check("wb_data",  bus.wb_data,  selected());
      check("wb_rd",    32'(bus.wb_rd), 32'(bus.mem_wb_register_rd));
      check("wb_en",    32'(bus.wb_en), 32'(commits()));
      check("wb_count", bus.wb_count, cnt);
      check("wb_count4", 32'(bus4.wb_count), 32'(cnt4));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      cnt  = 32'd0;
      cnt4 = 4'd0;

      // Initial reset edge without checks: storage is undefined before it.
      drive(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd9, 1'b0, 32'h1111_2222, 32'd0, 5'd9, 5'd9);
      cycle();

      // Every register reads zero after reset on both ports.
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 1'b0, 5'(a), 1'($urandom), $urandom, $urandom, 5'(a), 5'(31 - a));
         cycle();
      end

      // ALU result write, then read it back.
      drive(1'b0, 1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0);
      cycle();

      // Load data bypassed to both ports in the write cycle.
      drive(1'b0, 1'b1, 5'd7, 1'b1, 32'h0BAD_0BAD, 32'h1234_5678, 5'd7, 5'd7);
      cycle();

      // x0 write is a no-op.
      drive(1'b0, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7);
      cycle();

      // Reset wins over a simultaneous write, writes resume afterwards.
      drive(1'b1, 1'b1, 5'd3, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd3, 5'd3);
      cycle();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd5);
      cycle();
      drive(1'b0, 1'b1, 5'd3, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3);
      cycle();

      // Sixteen more commits wrap the 4-bit counter; writes still land.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 5'((i % 31) + 1), 1'(i), $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         cycle();
      end
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd16, 5'd1);
      cycle();

      // Random MEM/WB traffic with occasional resets and bypass-heavy addressing.
      for (int n = 0; n < 800; n++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 6),
               rd,
               1'($urandom),
               $urandom,
               $urandom,
               ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
